// File: rtl/hub75_scan_pkg.sv
// Shared types and panel geometry for the HUB75 1/32-scan driver.
package hub75_pkg;

  localparam int PANEL_W    = 64;
  localparam int PANEL_H    = 64;
  localparam int SCAN_LINES = 32;
  localparam int COL_W      = 6;
  localparam int LINE_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_U,
    FETCH_L,
    LOAD,
    SHIFT,
    LATCH,
    SHOW
  } state_t;

endpackage

// File: rtl/hub75_scan_if.sv
// Frame-buffer read port plus panel connector pins of the scan driver.
interface hub75_scan_if;
  import hub75_pkg::*;

  logic [LINE_W:0]      fb_addr;
  logic [PANEL_W-1:0]   fb_rdata;
  logic                 r_top;
  logic                 r_bot;
  logic                 sclk;
  logic                 lat;
  logic                 oe_n;
  logic [LINE_W-1:0]    row_addr;
  logic                 frame_done;

  modport master (
    output fb_addr, r_top, r_bot, sclk, lat, oe_n, row_addr, frame_done,
    input  fb_rdata
  );

  modport slave (
    input  fb_addr, r_top, r_bot, sclk, lat, oe_n, row_addr, frame_done,
    output fb_rdata
  );
endinterface

// File: rtl/hub75_line_shifter.sv
// Holds the upper/lower row words of one scan line and drives the registered
// column-serial pixel outputs.
module hub75_line_shifter
  import hub75_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_upper,
  input  logic               load_lower,
  input  logic               upd,
  input  logic [COL_W-1:0]   col,
  input  logic [PANEL_W-1:0] rdata,
  output logic               r_top,
  output logic               r_bot
);

  logic [PANEL_W-1:0] upper;
  logic [PANEL_W-1:0] lower;
  logic [PANEL_W-1:0] lower_src;

  // The lower word arrives on the same edge its first column must be driven.
  assign lower_src = load_lower ? rdata : lower;

  always_ff @(posedge clk) begin
    if (load_upper) upper <= rdata;
    if (load_lower) lower <= rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top <= 1'b0;
      r_bot <= 1'b0;
    end else if (upd) begin
      r_top <= upper[col];
      r_bot <= lower_src[col];
    end
  end

endmodule

// File: rtl/hub75_scan.sv
// HUB75 1/32-scan panel driver: fetch two rows, shift 64 columns, latch, show.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int ON_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  hub75_scan_if.master   bus
);

  localparam int ON_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(ON_CYCLES - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(SCAN_LINES - 1);
  localparam bit                ONE_SHOT  = (ON_CYCLES == 1);

  state_t             state, state_d;
  logic [LINE_W-1:0]  line, line_d;
  logic [COL_W-1:0]   col, col_d, upd_col;
  logic               phase, phase_d;
  logic [ON_W-1:0]    on_cnt, on_d;
  logic [LINE_W:0]    fb_addr_d;
  logic [LINE_W-1:0]  row_d;
  logic               sclk_d, lat_d, oe_n_d, fd_d;
  logic               ld_up, ld_lo, upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      line           <= '0;
      col            <= '0;
      phase          <= 1'b0;
      on_cnt         <= '0;
      bus.fb_addr    <= '0;
      bus.sclk       <= 1'b0;
      bus.lat        <= 1'b0;
      bus.oe_n       <= 1'b1;
      bus.row_addr   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_d;
      line           <= line_d;
      col            <= col_d;
      phase          <= phase_d;
      on_cnt         <= on_d;
      bus.fb_addr    <= fb_addr_d;
      bus.sclk       <= sclk_d;
      bus.lat        <= lat_d;
      bus.oe_n       <= oe_n_d;
      bus.row_addr   <= row_d;
      bus.frame_done <= fd_d;
    end
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d   = state;
    line_d    = line;
    col_d     = col;
    phase_d   = phase;
    on_d      = on_cnt;
    fb_addr_d = bus.fb_addr;
    row_d     = bus.row_addr;
    sclk_d    = 1'b0;
    lat_d     = 1'b0;
    oe_n_d    = 1'b1;
    fd_d      = 1'b0;
    ld_up     = 1'b0;
    ld_lo     = 1'b0;
    upd       = 1'b0;
    upd_col   = col;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_d   = FETCH_U;
          fb_addr_d = {1'b0, line};
        end
      end
      FETCH_U: begin
        state_d   = FETCH_L;
        fb_addr_d = {1'b1, line};
      end
      FETCH_L: begin
        ld_up   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        ld_lo   = 1'b1;
        state_d = SHIFT;
        col_d   = '1;
        phase_d = 1'b0;
        upd     = 1'b1;
        upd_col = '1;
      end
      SHIFT: begin
        if (!phase) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else if (col == '0) begin
          state_d = LATCH;
          lat_d   = 1'b1;
          row_d   = line;
        end else begin
          col_d   = col - COL_W'(1);
          phase_d = 1'b0;
          upd     = 1'b1;
          upd_col = col - COL_W'(1);
        end
      end
      LATCH: begin
        state_d = SHOW;
        oe_n_d  = 1'b0;
        on_d    = ON_LAST;
        fd_d    = ONE_SHOT && (line == LAST_LINE);
      end
      SHOW: begin
        if (on_cnt != '0) begin
          on_d   = on_cnt - ON_W'(1);
          oe_n_d = 1'b0;
          fd_d   = (on_cnt == ON_W'(1)) && (line == LAST_LINE);
        end else begin
          line_d = line + LINE_W'(1);
          if (en) begin
            state_d   = FETCH_U;
            fb_addr_d = {1'b0, line_d};
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  hub75_line_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_upper (ld_up),
    .load_lower (ld_lo),
    .upd        (upd),
    .col        (upd_col),
    .rdata      (bus.fb_rdata),
    .r_top      (bus.r_top),
    .r_bot      (bus.r_bot)
  );

endmodule
